// File: rtl/f_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// f_fetch_stage_pkg
// Shared constants for the fetch stage: reset PC, instruction-memory window
// and the nop encoding, plus the fetch-address legality check used to drive
// F_AdEL.
// ----------------------------------------------------------------------------
package f_fetch_stage_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam int unsigned IM_WORDS  = 4096;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One past the last legal byte address. Held in 33 bits so a window that
  // ends at the top of the address space cannot wrap to a small value.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  // 1 when pc is misaligned or outside [IM_BASE, IM_LIMIT). All unsigned.
  function automatic logic fetch_addr_illegal(input logic [31:0] pc);
    logic misaligned;
    logic below;
    logic above;
    misaligned = (pc[1:0] != 2'b00);
    below      = (pc < IM_BASE);
    above      = ({1'b0, pc} >= IM_LIMIT);
    return misaligned | below | above;
  endfunction

endpackage

// File: rtl/f_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// f_fetch_stage_if
// Bundles the fetch stage's control, next-PC, instruction-memory and F/D
// outputs.
//   slave  : seen by f_fetch_stage (takes Stall/D_Flush/Npc/F_Instr_in,
//            drives F_PC, F_AdEL, the D-side outputs and Stall_Cnt).
//   master : seen by the surrounding pipeline (hazard unit, next-PC logic, IM).
// ----------------------------------------------------------------------------
interface f_fetch_stage_if;

  logic        Stall;
  logic        D_Flush;
  logic [31:0] Npc;
  logic [31:0] F_Instr_in;
  logic [31:0] F_PC;
  logic        F_AdEL;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_Valid;
  logic        D_AdEL;
  logic [31:0] Stall_Cnt;

  modport slave (
    input  Stall, D_Flush, Npc, F_Instr_in,
    output F_PC, F_AdEL, D_PC, D_Instr, D_Valid, D_AdEL, Stall_Cnt
  );

  modport master (
    output Stall, D_Flush, Npc, F_Instr_in,
    input  F_PC, F_AdEL, D_PC, D_Instr, D_Valid, D_AdEL, Stall_Cnt
  );

endinterface

// File: rtl/f_fetch_stage_fd_pipe_reg.sv
// ----------------------------------------------------------------------------
// fd_pipe_reg
// F/D pipeline register. Priority: en=0 holds, en=1 with clr=1 inserts a
// bubble (nop, invalid), otherwise captures the fetched instruction.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   en              load enable (low while stalled)
//   clr             bubble insert, only honoured when en=1
//   pc_in/instr_in/adel_in   fetch-side values to capture
//   d_pc/d_instr/d_valid/d_adel  registered D-side outputs
// ----------------------------------------------------------------------------
module fd_pipe_reg
  import f_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        adel_in,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_valid,
  output logic        d_adel
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pc    <= 32'h0;
      d_instr <= NOP_INSTR;
      d_valid <= 1'b0;
      d_adel  <= 1'b0;
    end else if (en) begin
      if (clr) begin
        d_pc    <= 32'h0;
        d_instr <= NOP_INSTR;
        d_valid <= 1'b0;
        d_adel  <= 1'b0;
      end else begin
        d_pc    <= pc_in;
        d_instr <= instr_in;
        d_valid <= 1'b1;
        d_adel  <= adel_in;
      end
    end
  end

endmodule

// File: rtl/f_fetch_stage.sv
// ----------------------------------------------------------------------------
// f_fetch_stage
// Holds F_PC, loads Npc every unstalled edge, flags illegal fetch addresses
// and owns the F/D register and a saturating stall-cycle counter.
// Ports:
//   clk    rising-edge clock
//   reset  async active-high reset
//   bus    f_fetch_stage_if.slave:
//            in : Stall, D_Flush, Npc, F_Instr_in
//            out: F_PC, F_AdEL (combinational), D_PC, D_Instr, D_Valid,
//                 D_AdEL, Stall_Cnt
// ----------------------------------------------------------------------------
module f_fetch_stage
  import f_fetch_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  f_fetch_stage_if.slave bus
);

  logic [31:0] f_pc;
  logic        f_adel;
  logic [31:0] stall_cnt;
  logic [31:0] fetched_instr;

  assign f_adel = fetch_addr_illegal(f_pc);

  // An illegal fetch must never reach decode as a real instruction.
  assign fetched_instr = f_adel ? NOP_INSTR : bus.F_Instr_in;

  // Npc is loaded unchecked; illegal targets surface only through F_AdEL.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc <= PC_RESET;
    end else if (!bus.Stall) begin
      f_pc <= bus.Npc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'h0;
    end else if (bus.Stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Stall gates the enable, so a flush arriving with a stall is dropped.
  fd_pipe_reg u_fd_pipe_reg (
    .clk      (clk),
    .reset    (reset),
    .en       (!bus.Stall),
    .clr      (bus.D_Flush),
    .pc_in    (f_pc),
    .instr_in (fetched_instr),
    .adel_in  (f_adel),
    .d_pc     (bus.D_PC),
    .d_instr  (bus.D_Instr),
    .d_valid  (bus.D_Valid),
    .d_adel   (bus.D_AdEL)
  );

  assign bus.F_PC      = f_pc;
  assign bus.F_AdEL    = f_adel;
  assign bus.Stall_Cnt = stall_cnt;

endmodule

// File: tb/tb_f_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_f_fetch_stage
// Directed bench for f_fetch_stage. Inputs change 1 time unit after each
// rising edge; outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_f_fetch_stage;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic use_im;
  logic [31:0] instr_override;

  f_fetch_stage_if bus ();

  f_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: each word encodes its own address.
  function automatic logic [31:0] im_word(input logic [31:0] pc);
    return {16'h2408, pc[15:0]};
  endfunction

  assign bus.F_Instr_in = use_im ? im_word(bus.F_PC) : instr_override;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc,
                         input logic [31:0] instr, input logic valid,
                         input logic adel);
    check({tag, ".D_PC"},    bus.D_PC,           pc);
    check({tag, ".D_Instr"}, bus.D_Instr,        instr);
    check({tag, ".D_Valid"}, 32'(bus.D_Valid),   32'(valid));
    check({tag, ".D_AdEL"},  32'(bus.D_AdEL),    32'(adel));
  endtask

  initial begin
    logic [31:0] exp_pc;
    n_pass  = 0;
    n_total = 0;
    use_im  = 1'b1;
    instr_override = 32'h0;
    reset       = 1'b1;
    bus.Stall   = 1'b0;
    bus.D_Flush = 1'b0;
    bus.Npc     = 32'h0000_3004;

    // Power-on reset state.
    #2;
    check("por.F_PC",      bus.F_PC,      32'h0000_3000);
    check("por.F_AdEL",    32'(bus.F_AdEL), 32'd0);
    check("por.Stall_Cnt", bus.Stall_Cnt, 32'd0);
    check_d("por", 32'h0, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // Sequential fetch: D trails F by one word, D_Instr is the IM word.
    exp_pc = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      bus.Npc = exp_pc + 32'd4;
      step();
      check("seq.F_PC", bus.F_PC, exp_pc + 32'd4);
      check_d("seq", exp_pc, im_word(exp_pc), 1'b1, 1'b0);
      exp_pc = exp_pc + 32'd4;
    end
    // F_PC is now 0x3010.

    // Stall window: everything holds, counter reaches 3.
    bus.Stall = 1'b1;
    bus.Npc   = 32'h0000_3020;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall1.F_PC", bus.F_PC, 32'h0000_3010);
      check_d("stall1", 32'h0000_300C, im_word(32'h0000_300C), 1'b1, 1'b0);
    end
    check("stall1.Stall_Cnt", bus.Stall_Cnt, 32'd3);

    // Mid-cycle async reset takes effect without a clock edge.
    reset = 1'b1;
    #1;
    check("arst.F_PC",      bus.F_PC,      32'h0000_3000);
    check("arst.Stall_Cnt", bus.Stall_Cnt, 32'd0);
    check_d("arst", 32'h0, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    bus.Stall = 1'b0;

    // First fetch after reset with a specific instruction word.
    use_im = 1'b0;
    instr_override = 32'h3C01_1234;
    bus.Npc = 32'h0000_3004;
    step();
    check("first.F_PC", bus.F_PC, 32'h0000_3004);
    check_d("first", 32'h0000_3000, 32'h3C01_1234, 1'b1, 1'b0);

    // Stall for 3 cycles with Npc=0x3020, then release.
    bus.Stall = 1'b1;
    bus.Npc   = 32'h0000_3020;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall2.F_PC", bus.F_PC, 32'h0000_3004);
      check_d("stall2", 32'h0000_3000, 32'h3C01_1234, 1'b1, 1'b0);
    end
    check("stall2.Stall_Cnt", bus.Stall_Cnt, 32'd3);
    bus.Stall = 1'b0;
    use_im = 1'b1;
    step();
    check("release.F_PC", bus.F_PC, 32'h0000_3020);
    check("release.Stall_Cnt", bus.Stall_Cnt, 32'd3);
    check_d("release", 32'h0000_3004, im_word(32'h0000_3004), 1'b1, 1'b0);

    // Flush: bubble into D while F_PC loads Npc.
    bus.D_Flush = 1'b1;
    bus.Npc     = 32'h0000_3040;
    step();
    check("flush.F_PC", bus.F_PC, 32'h0000_3040);
    check_d("flush", 32'h0, 32'h0, 1'b0, 1'b0);
    bus.D_Flush = 1'b0;
    bus.Npc     = 32'h0000_3044;
    step();
    check("postflush.F_PC", bus.F_PC, 32'h0000_3044);
    check_d("postflush", 32'h0000_3040, im_word(32'h0000_3040), 1'b1, 1'b0);

    // Stall together with flush: stall wins, D held, counter increments.
    bus.Stall   = 1'b1;
    bus.D_Flush = 1'b1;
    bus.Npc     = 32'h0000_3048;
    step();
    check("stflush.F_PC", bus.F_PC, 32'h0000_3044);
    check("stflush.Stall_Cnt", bus.Stall_Cnt, 32'd4);
    check_d("stflush", 32'h0000_3040, im_word(32'h0000_3040), 1'b1, 1'b0);
    bus.Stall   = 1'b0;
    bus.D_Flush = 1'b0;

    // Misaligned Npc.
    bus.Npc = 32'h0000_3002;
    step();
    check("mis.F_PC",   bus.F_PC,         32'h0000_3002);
    check("mis.F_AdEL", 32'(bus.F_AdEL),  32'd1);

    // Upper bound: 0x7000 is one past the last legal word.
    bus.Npc = 32'h0000_7000;
    step();
    check("hi.F_AdEL", 32'(bus.F_AdEL), 32'd1);
    check_d("mis", 32'h0000_3002, 32'h0, 1'b1, 1'b1);

    // Last legal word.
    bus.Npc = 32'h0000_6FFC;
    step();
    check("last.F_AdEL", 32'(bus.F_AdEL), 32'd0);
    check_d("hi", 32'h0000_7000, 32'h0, 1'b1, 1'b1);

    // Just below IM_BASE.
    bus.Npc = 32'h0000_2FFC;
    step();
    check("lo.F_AdEL", 32'(bus.F_AdEL), 32'd1);
    check_d("last", 32'h0000_6FFC, im_word(32'h0000_6FFC), 1'b1, 1'b0);

    // Top of address space and wrap to zero.
    bus.Npc = 32'hFFFF_FFFC;
    step();
    check("top.F_AdEL", 32'(bus.F_AdEL), 32'd1);
    check_d("lo", 32'h0000_2FFC, 32'h0, 1'b1, 1'b1);
    exp_pc = 32'hFFFF_FFFC;
    bus.Npc = exp_pc + 32'd4;
    step();
    check("wrap.F_PC",   bus.F_PC,        32'h0000_0000);
    check("wrap.F_AdEL", 32'(bus.F_AdEL), 32'd1);
    check_d("top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);

    // Back to legal fetch.
    bus.Npc = 32'h0000_3000;
    step();
    check("back.F_AdEL", 32'(bus.F_AdEL), 32'd0);
    check("back.Stall_Cnt", bus.Stall_Cnt, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
